// File: rtl/irq_nest_ctrl.sv
// Interrupt sequencer between the HETI interrupt controller and the core: preemption, claim and level stack.
// Define IRQ_NEST_CTRL_NESTING_EN for a StackDepth-entry nesting stack; otherwise one handler runs at a time.
module irq_nest_ctrl #(
    parameter int unsigned NrIrqLines = 64,
    parameter int unsigned NrIrqPrios = 32,
    parameter int unsigned StackDepth = 4,
    localparam int unsigned IrqWidth   = $clog2(NrIrqLines),
    localparam int unsigned PrioWidth  = $clog2(NrIrqPrios),
    localparam int unsigned DepthWidth = $clog2(StackDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  irq_valid_i,
    input  logic [IrqWidth-1:0]   irq_id_i,
    input  logic [PrioWidth-1:0]  irq_level_i,
    input  logic                  irq_heti_i,
    input  logic                  irq_nest_i,
    output logic                  irq_ack_o,
    output logic [IrqWidth-1:0]   irq_id_o,
    output logic                  core_irq_req_o,
    output logic [IrqWidth-1:0]   core_irq_id_o,
    output logic                  core_irq_heti_o,
    input  logic                  core_irq_ack_i,
    input  logic                  core_mret_i,
    output logic [PrioWidth-1:0]  level_o,
    output logic [DepthWidth-1:0] depth_o,
    output logic                  err_o
);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_e;

    localparam logic [DepthWidth-1:0] DepthZero = {DepthWidth{1'b0}};
    localparam logic [DepthWidth-1:0] DepthOne  = DepthWidth'(1);
    localparam logic [DepthWidth-1:0] DepthMax  = DepthWidth'(StackDepth);
    localparam logic [PrioWidth-1:0]  LvlZero   = {PrioWidth{1'b0}};
    localparam logic [IrqWidth-1:0]   IdZero    = {IrqWidth{1'b0}};

    state_e                state_q, state_d;
    logic [IrqWidth-1:0]   lat_id_q, lat_id_d;
    logic [PrioWidth-1:0]  lat_lvl_q, lat_lvl_d;
    logic                  lat_heti_q, lat_heti_d;
    logic                  lat_nest_q, lat_nest_d;
    logic [PrioWidth-1:0]  cur_lvl_q, cur_lvl_d;
    logic                  cur_nest_q, cur_nest_d;
    logic [DepthWidth-1:0] depth_q, depth_d;
    logic                  err_q, err_d;
    logic                  ack_q, ack_d;
    logic [IrqWidth-1:0]   ack_id_q, ack_id_d;

    logic                  take_s;
    logic                  ack_s;
    logic                  pop_s;
    logic                  nest_in_s;
    logic [PrioWidth-1:0]  pop_lvl_s;
    logic                  pop_nest_s;
    logic [DepthWidth-1:0] push_depth_s;

    assign ack_s  = (state_q == REQ) & core_irq_ack_i;
    assign pop_s  = core_mret_i & (depth_q != DepthZero);
    assign take_s = (state_q == IDLE) & irq_valid_i & (irq_level_i != LvlZero)
                  & (irq_level_i > cur_lvl_q)
                  & ((depth_q == DepthZero) | (cur_nest_q & (depth_q < DepthMax)));

`ifdef IRQ_NEST_CTRL_NESTING_EN
    logic [PrioWidth-1:0] stk_lvl_q  [StackDepth];
    logic [PrioWidth-1:0] stk_lvl_d  [StackDepth];
    logic                 stk_nest_q [StackDepth];
    logic                 stk_nest_d [StackDepth];
    logic                 push_s;

    assign nest_in_s = irq_nest_i;
    // A tail-chained ack pops and re-pushes the same entry, so the array is left untouched.
    assign push_s       = ack_s & ~pop_s;
    assign push_depth_s = pop_s ? depth_q : depth_q + DepthOne;

    // Top-of-stack read and push write, decoded against depth so indices stay exact-width.
    always_comb begin
        pop_lvl_s  = LvlZero;
        pop_nest_s = 1'b0;
        for (int i = 0; i < int'(StackDepth); i++) begin
            pop_lvl_s     = (depth_q == DepthWidth'(i + 1)) ? stk_lvl_q[i]  : pop_lvl_s;
            pop_nest_s    = (depth_q == DepthWidth'(i + 1)) ? stk_nest_q[i] : pop_nest_s;
            stk_lvl_d[i]  = (push_s && (depth_q == DepthWidth'(i))) ? cur_lvl_q  : stk_lvl_q[i];
            stk_nest_d[i] = (push_s && (depth_q == DepthWidth'(i))) ? cur_nest_q : stk_nest_q[i];
        end
    end

    // Stack storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(StackDepth); i++) begin
                stk_lvl_q[i]  <= LvlZero;
                stk_nest_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(StackDepth); i++) begin
                stk_lvl_q[i]  <= stk_lvl_d[i];
                stk_nest_q[i] <= stk_nest_d[i];
            end
        end
    end
`else
    logic unused_nest_s;

    assign unused_nest_s = irq_nest_i;
    assign nest_in_s     = 1'b0;
    assign pop_lvl_s     = LvlZero;
    assign pop_nest_s    = 1'b0;
    assign push_depth_s  = DepthOne;
`endif

    // Request FSM, claim pulse and running-level bookkeeping.
    always_comb begin
        state_d    = state_q;
        lat_id_d   = lat_id_q;
        lat_lvl_d  = lat_lvl_q;
        lat_heti_d = lat_heti_q;
        lat_nest_d = lat_nest_q;
        cur_lvl_d  = cur_lvl_q;
        cur_nest_d = cur_nest_q;
        depth_d    = depth_q;
        err_d      = err_q | (core_mret_i & (depth_q == DepthZero));
        ack_d      = 1'b0;
        ack_id_d   = IdZero;

        case (state_q)
            IDLE: begin
                if (take_s) begin
                    state_d    = REQ;
                    lat_id_d   = irq_id_i;
                    lat_lvl_d  = irq_level_i;
                    lat_heti_d = irq_heti_i;
                    lat_nest_d = nest_in_s;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (core_irq_ack_i) begin
                    state_d  = IDLE;
                    ack_d    = 1'b1;
                    ack_id_d = lat_id_q;
                end else begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ack_s) begin
            cur_lvl_d  = lat_lvl_q;
            cur_nest_d = lat_nest_q;
            depth_d    = push_depth_s;
        end else if (pop_s) begin
            cur_lvl_d  = pop_lvl_s;
            cur_nest_d = pop_nest_s;
            depth_d    = depth_q - DepthOne;
        end else begin
            depth_d = depth_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            lat_id_q   <= IdZero;
            lat_lvl_q  <= LvlZero;
            lat_heti_q <= 1'b0;
            lat_nest_q <= 1'b0;
            cur_lvl_q  <= LvlZero;
            cur_nest_q <= 1'b0;
            depth_q    <= DepthZero;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            ack_id_q   <= IdZero;
        end else begin
            state_q    <= state_d;
            lat_id_q   <= lat_id_d;
            lat_lvl_q  <= lat_lvl_d;
            lat_heti_q <= lat_heti_d;
            lat_nest_q <= lat_nest_d;
            cur_lvl_q  <= cur_lvl_d;
            cur_nest_q <= cur_nest_d;
            depth_q    <= depth_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            ack_id_q   <= ack_id_d;
        end
    end

    assign core_irq_req_o  = (state_q == REQ);
    assign core_irq_id_o   = lat_id_q;
    assign core_irq_heti_o = lat_heti_q;
    assign irq_ack_o       = ack_q;
    assign irq_id_o        = ack_id_q;
    assign level_o         = cur_lvl_q;
    assign depth_o         = depth_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Bench for irq_nest_ctrl: directed scenarios with literal expectations, then random traffic vs a queue-based model.
module tb_irq_nest_ctrl;

`ifdef IRQ_NEST_CTRL_NESTING_EN
    localparam bit NEST_EN = 1'b1;
`else
    localparam bit NEST_EN = 1'b0;
`endif
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       irq_valid = 1'b0;
    logic [5:0] irq_id = 6'd0;
    logic [4:0] irq_level = 5'd0;
    logic       irq_heti = 1'b0;
    logic       irq_nest = 1'b0;
    logic       core_ack = 1'b0;
    logic       core_mret = 1'b0;

    logic       irq_ack_o;
    logic [5:0] irq_id_o;
    logic       core_irq_req_o;
    logic [5:0] core_irq_id_o;
    logic       core_irq_heti_o;
    logic [4:0] level_o;
    logic [2:0] depth_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    irq_nest_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .irq_valid_i    (irq_valid),
        .irq_id_i       (irq_id),
        .irq_level_i    (irq_level),
        .irq_heti_i     (irq_heti),
        .irq_nest_i     (irq_nest),
        .irq_ack_o      (irq_ack_o),
        .irq_id_o       (irq_id_o),
        .core_irq_req_o (core_irq_req_o),
        .core_irq_id_o  (core_irq_id_o),
        .core_irq_heti_o(core_irq_heti_o),
        .core_irq_ack_i (core_ack),
        .core_mret_i    (core_mret),
        .level_o        (level_o),
        .depth_o        (depth_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: running level/nest, a queue as the handler stack, one outstanding request.
    int  m_lvl = 0;
    bit  m_nest = 1'b0;
    int  m_depth = 0;
    int  stk_lvl[$];
    bit  stk_nest[$];
    bit  m_req = 1'b0;
    int  m_id = 0;
    int  m_llvl = 0;
    bit  m_heti = 1'b0;
    bit  m_lnest = 1'b0;
    bit  m_err = 1'b0;
    bit  m_ack = 1'b0;
    int  m_ack_id = 0;

    task automatic model_reset();
        m_lvl = 0; m_nest = 1'b0; m_depth = 0;
        stk_lvl.delete(); stk_nest.delete();
        m_req = 1'b0; m_id = 0; m_llvl = 0; m_heti = 1'b0; m_lnest = 1'b0;
        m_err = 1'b0; m_ack = 1'b0; m_ack_id = 0;
    endtask

    task automatic model_step();
        bit take, ackh, pop;
        take = !m_req && irq_valid && (irq_level != 5'd0) && (int'(irq_level) > m_lvl)
               && (m_depth == 0 || (m_nest && m_depth < SD));
        ackh = m_req && core_ack;
        pop  = core_mret && (m_depth > 0);
        m_ack = 1'b0;
        m_ack_id = 0;
        if (core_mret && m_depth == 0) m_err = 1'b1;
        if (pop) begin
            if (NEST_EN) begin
                m_lvl  = stk_lvl.pop_back();
                m_nest = stk_nest.pop_back();
            end else begin
                m_lvl  = 0;
                m_nest = 1'b0;
            end
            m_depth--;
        end
        if (ackh) begin
            if (NEST_EN) begin
                stk_lvl.push_back(m_lvl);
                stk_nest.push_back(m_nest);
                m_depth++;
            end else begin
                m_depth = 1;
            end
            m_lvl = m_llvl; m_nest = m_lnest;
            m_req = 1'b0; m_ack = 1'b1; m_ack_id = m_id;
        end
        if (take) begin
            m_req = 1'b1; m_id = int'(irq_id); m_llvl = int'(irq_level);
            m_heti = irq_heti; m_lnest = NEST_EN ? irq_nest : 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("req", int'(core_irq_req_o), int'(m_req));
        if (m_req) begin
            chk("req_id", int'(core_irq_id_o), m_id);
            chk("req_heti", int'(core_irq_heti_o), int'(m_heti));
        end
        chk("ack", int'(irq_ack_o), int'(m_ack));
        if (m_ack) chk("ack_id", int'(irq_id_o), m_ack_id);
        chk("level", int'(level_o), m_lvl);
        chk("depth", int'(depth_o), m_depth);
        chk("err", int'(err_o), int'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input int id, input int lvl, input bit nest, input bit ack, input bit mret);
        irq_valid = v; irq_id = 6'(id); irq_level = 5'(lvl); irq_heti = id[0];
        irq_nest = nest; core_ack = ack; core_mret = mret;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_req", int'(core_irq_req_o), 0);
        chk("rst_level", int'(level_o), 0);
        chk("rst_depth", int'(depth_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_ack", int'(irq_ack_o), 0);

        // Basic request and claim.
        drive(1'b1, 5, 3, 1'b1, 1'b0, 1'b0); tick();
        chk("t1_req", int'(core_irq_req_o), 1);
        chk("t1_req_id", int'(core_irq_id_o), 5);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0); tick();
        chk("t1_ack", int'(irq_ack_o), 1);
        chk("t1_ack_id", int'(irq_id_o), 5);
        chk("t1_level", int'(level_o), 3);
        chk("t1_depth", int'(depth_o), 1);
        chk("t1_req_drop", int'(core_irq_req_o), 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        chk("t1_ack_pulse", int'(irq_ack_o), 0);

        // Nested preemption and return.
        drive(1'b1, 9, 7, 1'b1, 1'b0, 1'b0); tick();
        chk("t2_req", int'(core_irq_req_o), NEST_EN ? 1 : 0);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0); tick();
        chk("t2_depth", int'(depth_o), NEST_EN ? 2 : 1);
        chk("t2_level", int'(level_o), NEST_EN ? 7 : 3);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1); tick();
        chk("t2_ret_level", int'(level_o), NEST_EN ? 3 : 0);
        chk("t2_ret_depth", int'(depth_o), NEST_EN ? 1 : 0);

        // Non-nestable handler, equal level, level zero, mret underflow.
        do_reset();
        drive(1'b1, 1, 3, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0); tick();
        chk("t3_level", int'(level_o), 3);
        drive(1'b1, 4, 7, 1'b1, 1'b0, 1'b0); tick(); tick();
        chk("t3_nonest", int'(core_irq_req_o), 0);
        drive(1'b1, 4, 3, 1'b1, 1'b0, 1'b0); tick(); tick();
        chk("t3_equal", int'(core_irq_req_o), 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b1, 4, 0, 1'b1, 1'b0, 1'b0); tick(); tick();
        chk("t3_lvl0", int'(core_irq_req_o), 0);
        chk("t3_depth0", int'(depth_o), 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1); tick();
        chk("t3_err", int'(err_o), 1);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0); tick(); tick();
        chk("t3_err_hold", int'(err_o), 1);

        // Stack full, then a pop releases the waiting winner.
        do_reset();
        for (int l = 1; l <= 4; l++) begin
            drive(1'b1, 10 + l, l, 1'b1, 1'b0, 1'b0); tick();
            drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0); tick();
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("t4_depth", int'(depth_o), NEST_EN ? 4 : 1);
        chk("t4_level", int'(level_o), NEST_EN ? 4 : 1);
        drive(1'b1, 20, 9, 1'b1, 1'b0, 1'b0); tick(); tick();
        chk("t4_full", int'(core_irq_req_o), 0);
        drive(1'b1, 20, 9, 1'b1, 1'b0, 1'b1); tick();
        chk("t4_pop_noreq", int'(core_irq_req_o), 0);
        chk("t4_pop_depth", int'(depth_o), NEST_EN ? 3 : 0);
        drive(1'b1, 20, 9, 1'b1, 1'b0, 1'b0); tick();
        chk("t4_req", int'(core_irq_req_o), 1);
        chk("t4_req_id", int'(core_irq_id_o), 20);

        // Tail-chain: ack and mret together.
        do_reset();
        drive(1'b1, 7, 4, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 2, 6, 1'b1, 1'b0, 1'b0); tick();
        chk("t5_req", int'(core_irq_req_o), NEST_EN ? 1 : 0);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b1); tick();
        chk("t5_ack", int'(irq_ack_o), NEST_EN ? 1 : 0);
        chk("t5_ack_id", int'(irq_id_o & {6{irq_ack_o}}), NEST_EN ? 2 : 0);
        chk("t5_level", int'(level_o), NEST_EN ? 6 : 0);
        chk("t5_depth", int'(depth_o), NEST_EN ? 1 : 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0); tick();

        // Asynchronous reset in the middle of a request.
        do_reset();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b1, 3, 2, 1'b0, 1'b0, 1'b0); tick();
        chk("t6_err", int'(err_o), 1);
        chk("t6_req", int'(core_irq_req_o), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", int'(core_irq_req_o), 0);
        chk("t6_rst_err", int'(err_o), 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (c % 1000 == 999) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      (m_depth > 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 63) == 0));
                tick();
            end
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
